// File: rtl/ltl_symbol_encoder.sv
// Event-to-symbol encoder feeding one LTL automata monitor: buffers proposition
// vectors in a small FIFO and sequences the monitor's reset on each trace restart.
module ltl_symbol_encoder #(
  parameter int unsigned NUM_PROPS  = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ev_valid,
  input  logic [NUM_PROPS-1:0] ev_props,
  output logic                 ev_ready,
  input  logic                 trace_start,
  input  logic                 mon_en,
  output logic [7:0]           symbols,
  output logic                 run,
  output logic                 mon_reset,
  output logic [CNT_W-1:0]     sym_count,
  output logic [7:0]           drop_count,
  output logic                 busy
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RstLast = RCW'(RST_CYCLES - 1);

  typedef enum logic {StMrst, StRun} state_e;

  state_e           state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       symbols_q, symbols_d;
  logic             run_q, run_d;
  logic             mon_reset_q, mon_reset_d;
  logic [CNT_W-1:0] sym_count_q, sym_count_d;
  logic [7:0]       drop_q, drop_d;
  logic             full, empty, push, pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ev_ready = (state_q == StRun) && !full;
  assign push     = ev_valid && ev_ready;
  // A restart suppresses the pop so flushed entries never reach the monitor.
  assign pop      = (state_q == StRun) && !empty && mon_en && !trace_start;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    symbols_d   = symbols_q;
    run_d       = 1'b0;
    sym_count_d = sym_count_q;
    drop_d      = drop_q;

    if (trace_start) begin
      state_d     = StMrst;
      rst_cnt_d   = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      sym_count_d = '0;
    end else begin
      if (state_q == StMrst) begin
        if (rst_cnt_q == RstLast) begin
          state_d   = StRun;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        symbols_d   = mem_q[rd_ptr_q[AW-1:0]];
        run_d       = 1'b1;
        sym_count_d = sym_count_q + 1'b1;
      end
    end

    mon_reset_d = (state_d == StMrst);

    if (ev_valid && !ev_ready && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StMrst;
      rst_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      symbols_q   <= '0;
      run_q       <= 1'b0;
      mon_reset_q <= 1'b1;
      sym_count_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      symbols_q   <= symbols_d;
      run_q       <= run_d;
      mon_reset_q <= mon_reset_d;
      sym_count_q <= sym_count_d;
      drop_q      <= drop_d;
    end
  end

  // Storage needs no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= 8'(ev_props);
    end
  end

  assign symbols    = symbols_q;
  assign run        = run_q;
  assign mon_reset  = mon_reset_q;
  assign sym_count  = sym_count_q;
  assign drop_count = drop_q;
  assign busy       = !empty || (state_q != StRun);

endmodule

// File: tb/tb_ltl_symbol_encoder.sv
// Bench for ltl_symbol_encoder: a scoreboard follows accepted events to the
// symbol output while the main thread checks reset, overflow and restart timing.
module tb_ltl_symbol_encoder;

  logic        clk;
  logic        reset;
  logic        ev_valid;
  logic [5:0]  ev_props;
  logic        ev_ready;
  logic        trace_start;
  logic        mon_en;
  logic [7:0]  symbols;
  logic        run;
  logic        mon_reset;
  logic [15:0] sym_count;
  logic [7:0]  drop_count;
  logic        busy;

  int n_checks = 0;
  int n_bad    = 0;
  logic [7:0] exp_q[$];

  ltl_symbol_encoder #(
    .NUM_PROPS  (6),
    .FIFO_DEPTH (4),
    .RST_CYCLES (2),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ev_valid    (ev_valid),
    .ev_props    (ev_props),
    .ev_ready    (ev_ready),
    .trace_start (trace_start),
    .mon_en      (mon_en),
    .symbols     (symbols),
    .run         (run),
    .mon_reset   (mon_reset),
    .sym_count   (sym_count),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare issued symbols, then record accepts, then apply flush.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (run) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        check("sb_excl", 32'(mon_reset), 32'd0);
        if (exp_q.size() > 0) begin
          check("sb_symbol", 32'(symbols), 32'(exp_q.pop_front()));
        end
      end
      if (ev_valid && ev_ready) exp_q.push_back({2'b00, ev_props});
      if (trace_start) exp_q.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ovf [6];
    int sent;
    int guard;
    ovf[0] = 6'h01; ovf[1] = 6'h02; ovf[2] = 6'h04;
    ovf[3] = 6'h08; ovf[4] = 6'h10; ovf[5] = 6'h20;

    reset = 1'b1; ev_valid = 1'b0; ev_props = '0; trace_start = 1'b0; mon_en = 1'b0;
    repeat (3) tick();
    check("rst_symbols", 32'(symbols), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_mon_reset", 32'(mon_reset), 32'd1);
    check("rst_ev_ready", 32'(ev_ready), 32'd0);
    check("rst_sym_count", 32'(sym_count), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // Reset release: two cycles of monitor reset, then ready.
    reset = 1'b0;
    check("rel0_mon_reset", 32'(mon_reset), 32'd1);
    tick();
    check("rel1_mon_reset", 32'(mon_reset), 32'd1);
    check("rel1_ev_ready", 32'(ev_ready), 32'd0);
    tick();
    check("rel2_mon_reset", 32'(mon_reset), 32'd0);
    check("rel2_ev_ready", 32'(ev_ready), 32'd1);
    check("rel2_sym_count", 32'(sym_count), 32'd0);
    check("rel2_drop", 32'(drop_count), 32'd0);
    check("rel2_busy", 32'(busy), 32'd0);

    // Streaming, two-cycle latency.
    mon_en = 1'b1; ev_valid = 1'b1; ev_props = 6'h05;
    tick();
    check("str_run_early", 32'(run), 32'd0);
    ev_props = 6'h2A;
    tick();
    check("str_sym0", 32'(symbols), 32'h05);
    check("str_run0", 32'(run), 32'd1);
    ev_props = 6'h3F;
    tick();
    check("str_sym1", 32'(symbols), 32'h2A);
    ev_valid = 1'b0;
    tick();
    check("str_sym2", 32'(symbols), 32'h3F);
    check("str_run2", 32'(run), 32'd1);
    tick();
    check("str_run_end", 32'(run), 32'd0);
    check("str_sym_count", 32'(sym_count), 32'd3);

    // Overflow with the monitor stalled.
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("ovf_ready", 32'(ev_ready), (i < 4) ? 32'd1 : 32'd0);
      ev_valid = 1'b1;
      ev_props = ovf[i];
      tick();
    end
    ev_valid = 1'b0;
    check("ovf_drop", 32'(drop_count), 32'd2);
    check("ovf_ready_full", 32'(ev_ready), 32'd0);
    check("ovf_busy", 32'(busy), 32'd1);
    mon_en = 1'b1;
    repeat (8) tick();
    check("ovf_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_sym_count", 32'(sym_count), 32'd7);
    check("ovf_busy_idle", 32'(busy), 32'd0);

    // Wrap-around with mon_en toggling; offer events only when ready.
    sent = 0;
    guard = 0;
    while (sent < 10 && guard < 200) begin
      mon_en = ~mon_en;
      if (ev_ready) begin
        ev_valid = 1'b1;
        ev_props = 6'(sent * 7 + 3);
        sent++;
      end else begin
        ev_valid = 1'b0;
      end
      tick();
      guard++;
    end
    ev_valid = 1'b0;
    repeat (20) begin
      mon_en = ~mon_en;
      tick();
    end
    check("wrap_sent", 32'(sent), 32'd10);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);
    check("wrap_drop", 32'(drop_count), 32'd2);
    check("wrap_sym_count", 32'(sym_count), 32'd17);

    // Restart with three symbols buffered plus one accepted in the restart cycle.
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev_valid = 1'b1;
      ev_props = 6'(6'h21 + i);
      tick();
    end
    check("rs_ready_before", 32'(ev_ready), 32'd1);
    trace_start = 1'b1; ev_valid = 1'b1; ev_props = 6'h24;
    tick();
    trace_start = 1'b0; ev_valid = 1'b0; mon_en = 1'b1;
    check("rs1_mon_reset", 32'(mon_reset), 32'd1);
    check("rs1_run", 32'(run), 32'd0);
    check("rs1_sym_count", 32'(sym_count), 32'd0);
    check("rs1_ev_ready", 32'(ev_ready), 32'd0);
    tick();
    check("rs2_mon_reset", 32'(mon_reset), 32'd1);
    check("rs2_run", 32'(run), 32'd0);
    tick();
    check("rs3_mon_reset", 32'(mon_reset), 32'd0);
    check("rs3_run", 32'(run), 32'd0);
    check("rs3_ev_ready", 32'(ev_ready), 32'd1);
    check("rs3_busy", 32'(busy), 32'd0);
    check("rs3_drop", 32'(drop_count), 32'd2);
    ev_valid = 1'b1; ev_props = 6'h15;
    tick();
    ev_valid = 1'b0;
    check("rs4_run", 32'(run), 32'd0);
    tick();
    check("rs5_symbol", 32'(symbols), 32'h15);
    check("rs5_run", 32'(run), 32'd1);
    tick();
    check("rs6_sym_count", 32'(sym_count), 32'd1);

    // All propositions true: upper symbol bits stay zero.
    ev_valid = 1'b1; ev_props = 6'h3F;
    tick();
    ev_valid = 1'b0;
    tick();
    check("full_props_sym", 32'(symbols), 32'h3F);
    check("full_props_hi", 32'(symbols[7:6]), 32'd0);

    // Hold MRST via trace_start with events offered: drop counter saturates.
    trace_start = 1'b1; ev_valid = 1'b1; ev_props = 6'h01;
    repeat (50) tick();
    check("sat_mid", 32'(drop_count), 32'd51);
    repeat (250) tick();
    check("sat_end", 32'(drop_count), 32'd255);
    trace_start = 1'b0; ev_valid = 1'b0;
    repeat (3) tick();
    check("sat_kept", 32'(drop_count), 32'd255);
    check("sat_mon_reset", 32'(mon_reset), 32'd0);

    // Only reset clears the drop counter.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_drop", 32'(drop_count), 32'd0);
    check("rst2_symbols", 32'(symbols), 32'd0);
    check("rst2_mon_reset", 32'(mon_reset), 32'd1);
    check("rst2_ev_ready", 32'(ev_ready), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
